// File: rtl/writeback_unit.sv
// Register-bank writeback arbiter: merges single-cycle ALU results with a ready/valid
// load path through a one-entry holding buffer, and tracks pending-load busy bits.
module writeback_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_val,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_val,
    input  logic        iss_valid,
    input  logic        iss_is_load,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    output logic        q_rs1_busy,
    output logic        q_rs2_busy,
    output logic        reg_we,
    output logic [4:0]  rd,
    output logic [31:0] rd_val
);

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t  state, state_next;
    logic [4:0]  buf_rd;
    logic [31:0] buf_val;
    logic [31:0] busy, busy_next;

    logic        mem_xfer;
    logic        capture;
    logic        sel_valid;
    logic        sel_mem;
    logic [4:0]  sel_rd;
    logic [31:0] sel_val;

    assign mem_ready = (state == EMPTY);
    assign mem_xfer  = mem_valid && mem_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next = state;
        capture    = 1'b0;
        sel_valid  = 1'b0;
        sel_mem    = 1'b0;
        sel_rd     = '0;
        sel_val    = '0;

        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_val   = alu_val;
            if (mem_xfer) begin
                capture    = 1'b1;
                state_next = FULL;
            end
        end else if (state == FULL) begin
            sel_valid  = 1'b1;
            sel_mem    = 1'b1;
            sel_rd     = buf_rd;
            sel_val    = buf_val;
            state_next = EMPTY;
        end else if (mem_xfer) begin
            sel_valid = 1'b1;
            sel_mem   = 1'b1;
            sel_rd    = mem_rd;
            sel_val   = mem_val;
        end

        // Clear before set so a same-cycle issue to the same register keeps it busy.
        busy_next = busy;
        if (sel_valid && sel_mem)
            busy_next[sel_rd] = 1'b0;
        if (iss_valid && iss_is_load)
            busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) begin
            state  <= EMPTY;
            busy   <= '0;
            reg_we <= 1'b0;
            rd     <= '0;
            rd_val <= '0;
        end else begin
            state  <= state_next;
            busy   <= busy_next;
            reg_we <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                rd     <= sel_rd;
                rd_val <= sel_val;
            end
        end
    end

    // NOTE: buffer payload has no reset; it is only ever read while state is FULL.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_rd  <= mem_rd;
            buf_val <= mem_val;
        end
    end

    assign q_rs1_busy = (q_rs1 != 5'd0) && busy[q_rs1];
    assign q_rs2_busy = (q_rs2 != 5'd0) && busy[q_rs2];

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected register writes,
// a negedge monitor pops and compares every reg_we pulse.
module tb_writeback_unit;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, iss_valid, iss_is_load;
    logic [4:0]  alu_rd, mem_rd, iss_rd, q_rs1, q_rs2;
    logic [31:0] alu_val, mem_val;
    logic        mem_ready, q_rs1_busy, q_rs2_busy, reg_we;
    logic [4:0]  rd;
    logic [31:0] rd_val;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_val(mem_val),
        .iss_valid(iss_valid), .iss_is_load(iss_is_load), .iss_rd(iss_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rs1_busy(q_rs1_busy), .q_rs2_busy(q_rs2_busy),
        .reg_we(reg_we), .rd(rd), .rd_val(rd_val)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_val = 0;
        mem_valid = 0; mem_rd = 0; mem_val = 0;
        iss_valid = 0; iss_is_load = 0; iss_rd = 0;
    endtask

    task automatic expect_write(input logic [4:0] r, input logic [31:0] v);
        wr_t w;
        w.rd  = r;
        w.val = v;
        exp_q.push_back(w);
    endtask

    // Monitor: every observed write must match the oldest expected write.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && reg_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_rd", {27'd0, rd}, 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_rd", {27'd0, rd}, {27'd0, w.rd});
                    check("wr_val", rd_val, w.val);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        q_rs1 = 0; q_rs2 = 0;
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step();
        check("rst_reg_we", {31'd0, reg_we}, 32'd0);
        check("rst_rd", {27'd0, rd}, 32'd0);
        check("rst_rd_val", rd_val, 32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        check("rst_q1", {31'd0, q_rs1_busy}, 32'd0);
        check("rst_q2", {31'd0, q_rs2_busy}, 32'd0);

        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_val = 32'hDEADBEEF;
        expect_write(5, 32'hDEADBEEF);
        step(); idle_inputs();
        check("alu_we", {31'd0, reg_we}, 32'd1);
        check("alu_rd", {27'd0, rd}, 32'd5);
        step();
        check("alu_we_drop", {31'd0, reg_we}, 32'd0);
        check("idle_rd_hold", {27'd0, rd}, 32'd5);

        // ALU and memory collide: memory result goes through the buffer
        alu_valid = 1; alu_rd = 3; alu_val = 32'h11;
        mem_valid = 1; mem_rd = 7; mem_val = 32'h22;
        expect_write(3, 32'h11);
        expect_write(7, 32'h22);
        step(); idle_inputs();
        check("collide_rd_alu", {27'd0, rd}, 32'd3);
        check("collide_ready_full", {31'd0, mem_ready}, 32'd0);
        step();
        check("collide_rd_mem", {27'd0, rd}, 32'd7);
        check("collide_val_mem", rd_val, 32'h22);
        check("collide_ready_empty", {31'd0, mem_ready}, 32'd1);
        step();
        check("collide_we_drop", {31'd0, reg_we}, 32'd0);

        // Busy tracking for r9
        iss_valid = 1; iss_is_load = 1; iss_rd = 9;
        step(); idle_inputs();
        q_rs1 = 9;
        #1 check("busy9_set", {31'd0, q_rs1_busy}, 32'd1);
        alu_valid = 1; alu_rd = 9; alu_val = 32'h99;
        expect_write(9, 32'h99);
        step(); idle_inputs();
        check("busy9_after_alu", {31'd0, q_rs1_busy}, 32'd1);
        mem_valid = 1; mem_rd = 9; mem_val = 32'hAB;
        expect_write(9, 32'hAB);
        step(); idle_inputs();
        check("busy9_cleared", {31'd0, q_rs1_busy}, 32'd0);

        // Set wins over clear on r12
        iss_valid = 1; iss_is_load = 1; iss_rd = 12;
        step(); idle_inputs();
        q_rs2 = 12;
        mem_valid = 1; mem_rd = 12; mem_val = 32'hC0C0;
        iss_valid = 1; iss_is_load = 1; iss_rd = 12;
        expect_write(12, 32'hC0C0);
        step(); idle_inputs();
        check("busy12_set_wins", {31'd0, q_rs2_busy}, 32'd1);
        mem_valid = 1; mem_rd = 12; mem_val = 32'hC1C1;
        expect_write(12, 32'hC1C1);
        step(); idle_inputs();
        check("busy12_cleared", {31'd0, q_rs2_busy}, 32'd0);

        // Register 0: write discarded, never busy
        mem_valid = 1; mem_rd = 0; mem_val = 32'h55;
        step(); idle_inputs();
        check("r0_no_we", {31'd0, reg_we}, 32'd0);
        iss_valid = 1; iss_is_load = 1; iss_rd = 0;
        step(); idle_inputs();
        q_rs1 = 0;
        #1 check("r0_never_busy", {31'd0, q_rs1_busy}, 32'd0);

        // Ordering through the buffer, with busy cleared by the buffered write
        alu_valid = 1; alu_rd = 1; alu_val = 32'h101;
        mem_valid = 1; mem_rd = 4; mem_val = 32'h404;
        iss_valid = 1; iss_is_load = 1; iss_rd = 4;
        expect_write(1, 32'h101);
        expect_write(4, 32'h404);
        expect_write(6, 32'h606);
        step(); idle_inputs();
        q_rs1 = 4;
        #1 check("busy4_while_buffered", {31'd0, q_rs1_busy}, 32'd1);
        mem_valid = 1; mem_rd = 6; mem_val = 32'h606;
        check("order_ready_low", {31'd0, mem_ready}, 32'd0);
        step();
        check("busy4_cleared", {31'd0, q_rs1_busy}, 32'd0);
        check("order_ready_high", {31'd0, mem_ready}, 32'd1);
        step(); idle_inputs();
        step();

        // Buffer held under sustained ALU traffic, then reset discards it
        iss_valid = 1; iss_is_load = 1; iss_rd = 8;
        step(); idle_inputs();
        q_rs1 = 8;
        for (int k = 0; k < 5; k++) begin
            alu_valid = 1; alu_rd = 2; alu_val = 32'h200 + k;
            if (k == 0) begin
                mem_valid = 1; mem_rd = 8; mem_val = 32'h88;
            end
            expect_write(2, 32'h200 + k);
            step();
            mem_valid = 0;
            check("hold_ready_low", {31'd0, mem_ready}, 32'd0);
        end
        check("hold_busy8", {31'd0, q_rs1_busy}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 0;
        idle_inputs();
        #1;
        check("rst_mid_we", {31'd0, reg_we}, 32'd0);
        check("rst_mid_ready", {31'd0, mem_ready}, 32'd1);
        check("rst_mid_busy8", {31'd0, q_rs1_busy}, 32'd0);
        step(); step();
        rst_n = 1;
        step(); step(); step();
        check("post_rst_ready", {31'd0, mem_ready}, 32'd1);
        check("post_rst_busy8", {31'd0, q_rs1_busy}, 32'd0);
        check("post_rst_we", {31'd0, reg_we}, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 alu_valid  input  1  single-cycle ALU result present this cycle; always accepted, no backpressure.
REQ-005 alu_rd  input  5  ALU destination register index.
REQ-006 alu_val  input  32  ALU result data.
REQ-007 mem_valid  input  1  load result offered by memory path.
REQ-008 mem_ready  output  1  block can accept a load result this cycle.
REQ-009 mem_rd  input  5  load destination register index.
REQ-010 mem_val  input  32  load result data.
REQ-011 iss_valid  input  1  instruction issued this cycle.
REQ-012 iss_is_load  input  1  the issued instruction is a load.
REQ-013 iss_rd  input  5  destination of the issued instruction.
REQ-014 q_rs1, q_rs2  input  5 each  register indices queried for pending-load status.
REQ-015 q_rs1_busy, q_rs2_busy  output  1 each  queried register awaits a load result.
REQ-016 reg_we  output  1  register-bank write enable.
REQ-017 rd  output  5  register-bank write address.
REQ-018 rd_val  output  32  register-bank write data.

Function
REQ-019 reg_we, rd and rd_val SHALL be registered; a result selected in cycle N SHALL appear on them in cycle N+1.
REQ-020 A memory transfer SHALL occur when mem_valid and mem_ready are both high on a rising clk edge.
REQ-021 The block SHALL contain a one-entry holding buffer with two states: EMPTY and FULL.
REQ-022 mem_ready SHALL equal 1 when the buffer is EMPTY and 0 when it is FULL (combinational from state).
REQ-023 Selection priority each cycle SHALL be: alu_valid first, then buffer contents, then a transferring memory result.
REQ-024 If alu_valid and a memory transfer coincide, the ALU result SHALL be written and the memory result captured into the buffer (EMPTY->FULL).
REQ-025 If the buffer is FULL and alu_valid is low, the buffered result SHALL be written and the buffer SHALL go FULL->EMPTY.
REQ-026 If the buffer is FULL and alu_valid is high, the buffer SHALL hold; there SHALL be no bound on the hold time.
REQ-027 If the buffer is EMPTY, alu_valid is low and a memory transfer occurs, the memory result SHALL be written directly and the buffer SHALL stay EMPTY.
REQ-028 If nothing is selected, reg_we SHALL be 0 next cycle; rd and rd_val SHALL hold their previous values.
REQ-029 A selected result with destination 0 SHALL produce reg_we=0 (write discarded); buffering and busy clearing SHALL be unaffected.
REQ-030 The block SHALL keep busy bits for registers 1..31; register 0 SHALL never be busy.
REQ-031 iss_valid&iss_is_load with iss_rd!=0 SHALL set busy[iss_rd] at the clock edge.
REQ-032 Writing a memory-path result (direct or buffered) to reg_we SHALL clear busy[rd] at that edge; an ALU write SHALL NOT change busy.
REQ-033 If a set and a clear target the same register in the same cycle, set SHALL win.
REQ-034 q_rs1_busy and q_rs2_busy SHALL be combinational from the busy bits; an index of 0 SHALL return 0.
REQ-035 Memory results SHALL be written in acceptance order; no reordering SHALL occur between memory results.

Reset
REQ-036 While rst_n=0, and immediately on assertion, the block SHALL force buffer=EMPTY, all busy bits=0, reg_we=0, rd=0 and rd_val=0, which makes mem_ready=1.
REQ-037 Reset asserted mid-operation SHALL discard any buffered result without writing it.

Verification
REQ-038 Reset release with all inputs at 0 -> reg_we=0, rd=0, rd_val=0, mem_ready=1, both query outputs 0.
REQ-039 alu_valid=1, alu_rd=5, alu_val=0xDEADBEEF for one cycle -> next cycle reg_we=1, rd=5, rd_val=0xDEADBEEF; the cycle after, reg_we=0.
REQ-040 Same cycle: ALU (rd=3, 0x11) and memory transfer (rd=7, 0x22) -> cycle+1 writes r3=0x11 with mem_ready=0; cycle+2 (ALU idle) writes r7=0x22 with mem_ready=1.
REQ-041 Issue a load to r9 -> q_rs1=9 gives busy=1; memory writes r9 -> busy clears on that edge; an ALU write to r9 meanwhile leaves busy=1.
REQ-042 Memory result to r0 -> reg_we stays 0; ALU issue of a load to r0 -> q_rs1=0 gives busy=0.
REQ-043 Buffer FULL with alu_valid held high for 4 cycles, then rst_n pulsed low -> the buffered value is never written, mem_ready=1, busy=0.
